// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and FSM state encoding
// Purpose: constants common to the UART transmit and receive paths.
// Contents: uart_state_e (IDLE/START/DATA/STOP), DATA_BITS, START_LVL, STOP_LVL.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Purpose: generic synchronous FIFO; full/empty derive from the registered count.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (flushes contents)
//   push_i, push_data_i write request and data; ignored while full
//   pop_i               read request; ignored while empty
//   pop_data_o          head of queue (valid while not empty)
//   full_o, empty_o     occupancy flags
//   count_o             entries currently stored
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    // A pop in the same cycle does not make room: full is judged on the registered count.
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i & ~full_o;
    assign pop_ok     = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers are exactly AW bits wide and wrap on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - buffered 8N1 UART transmitter with byte FIFO
// Purpose: queue bytes from on-chip producers and send them back-to-back as 8N1 frames.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   wr_en_in         write strobe; byte taken when full_op is low
//   wr_data_in       byte to queue
//   full_op          FIFO holds DEPTH bytes
//   count_op         bytes queued, not counting the byte on the line
//   busy_op          a frame (START, DATA or STOP) is on the line
//   tx_done_op       one-cycle pulse after the last stop-bit cycle
//   tx_out_op        serial line, idles high
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_en_in,
    input  logic [7:0]               wr_data_in,
    output logic                     full_op,
    output logic [$clog2(DEPTH):0]   count_op,
    output logic                     busy_op,
    output logic                     tx_done_op,
    output logic                     tx_out_op
);

    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [TW-1:0]    TMAX     = TW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pop;
    logic                 bit_end;
    logic                 fifo_empty;
    logic [7:0]           fifo_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .push_i      (wr_en_in),
        .push_data_i (wr_data_in),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (full_op),
        .empty_o     (fifo_empty),
        .count_o     (count_op)
    );

    assign bit_end    = (timer_q == TMAX);
    assign busy_op    = busy_q;
    assign tx_done_op = done_q;
    assign tx_out_op  = tx_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        if (state_q != ST_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = START_LVL;
                    busy_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        tx_d    = STOP_LVL;
                        state_d = ST_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = START_LVL;
                        state_d = ST_START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Buffered 8N1 UART transmitter: accepts bytes from on-chip logic through a write-strobe interface into an internal FIFO and serializes them onto the UART TX line back-to-back. It is the outbound end of the serial link, the counterpart to the receive path. Any producer, such as a command responder or status reporter, can queue a burst of bytes without waiting on each frame. Default baud is 115200 from a 100 MHz clock.

## Interface
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); must be ≥ 2
- DEPTH, 16, FIFO depth in bytes; power of two, ≥ 2
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  reset; synchronous, active-high
- wr_en_in  input  1  write strobe; byte accepted when high and full_op low
- wr_data_in  input  8  byte to queue
- full_op  output  1  FIFO holds DEPTH bytes
- count_op  output  $clog2(DEPTH)+1  bytes currently queued, excluding the byte being shifted
- busy_op  output  1  a frame is on the line (START, DATA or STOP)
- tx_done_op  output  1  one-cycle pulse at the end of each stop bit
- tx_out_op  output  1  serial line; idles high

## Operation
- Reset values:
  - tx_out_op = 1.
  - full_op, busy_op, tx_done_op = 0.
  - count_op = 0.
  - FIFO is flushed and the FSM is in IDLE.
- Write acceptance:
  - A write is accepted on a clock edge with wr_en_in=1 and full_op=0.
  - A write while full is silently dropped; FIFO state is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, drive tx_out_op=0 and go to START.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits, LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7. After bit 7, drive 1 and go to STOP.
  - STOP: hold for CLKS_PER_BIT cycles, then pulse tx_done_op.
    - If the FIFO is non-empty, pop and go directly to START on the same edge (no idle gap).
    - Otherwise go to IDLE.
- Bit-timer: counts 0..CLKS_PER_BIT-1, resets on every bit boundary, width $clog2(CLKS_PER_BIT).
- Simultaneous push and pop in one cycle: count_op is unchanged and both take effect.
- When full, a pop in the same cycle does not make room; full_op is evaluated on the registered count.
- Reset mid-frame:
  - Line returns high on the next cycle.
  - The frame is abandoned with no tx_done_op pulse.
  - All queued bytes are discarded.
- Data is never modified, reordered or duplicated.

## Timing
- Write accepted at edge k into an empty FIFO while in IDLE:
  - The pop occurs at edge k+1 and tx_out_op is low from edge k+1.
  - Latency is 1 cycle.
- Frame length is exactly 10·CLKS_PER_BIT cycles, measured from start falling edge to the end of the stop bit.
- tx_done_op is high for the single cycle following the last stop-bit cycle. This coincides with the next start bit when a byte is queued.
- busy_op is high from the first START cycle through the last STOP cycle.
- busy_op stays high continuously across back-to-back frames.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP).
  - DATA_BITS=8.
  - START_LVL=0, STOP_LVL=1.
  - The same constants are reused by the receiver.
- One sub-module, sync_fifo:
  - Parameterized width/depth, registered count, full/empty.
  - Pointers of $clog2(DEPTH) bits that wrap naturally.
  - Reusable elsewhere in the design.
- Top of block holds the FSM, bit-timer, bit index and shift register.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH=16.
- Reset:
  - Stimulus: hold rst_in for 3 cycles.
  - Response: tx_out_op=1, count_op=0, full_op=0, busy_op=0, tx_done_op=0; line stays high with no writes.
- Single byte:
  - Stimulus: write 0xA5 at cycle 0.
  - Response: line low during cycles 1–4. Data bits 1,0,1,0,0,1,0,1, each 4 cycles. Stop high during cycles 37–40. tx_done_op high only in cycle 41.
- Burst:
  - Stimulus: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Response: 30 contiguous bit periods with no idle bits between frames, bytes in order, 3 tx_done_op pulses spaced 40 cycles apart.
- Overflow:
  - Stimulus: write 0x00..0x11 (18 bytes) on consecutive cycles.
  - Response: count_op peaks at 16 and full_op asserts. Byte 0x11 is dropped. Exactly 0x00..0x10 (17 bytes) appear on the line.
- Push/pop collision:
  - Stimulus: with count_op=1, write a byte in the same cycle the STOP→START pop occurs.
  - Response: count_op stays 1 and both bytes transmit in order.
- Reset mid-frame:
  - Stimulus: assert rst_in during data bit 3 with 4 bytes queued.
  - Response: tx_out_op=1 next cycle, count_op=0, no tx_done_op pulse, line idle afterwards.
